multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised multi-cycle control FSM for the MIPS-subset CPU; generation after the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on a memory ready handshake.
- Drives per-state strobes to the datapath, register file, ALU control and memory.
- Adds `jal`/`jr` linkage, a distinct `subi` opcode, illegal-opcode trapping and a memory-timeout watchdog.

Parameters:
- `ALUOP_W`, 3, width of `alu_op`.
- `TIMEOUT_CYC`, 15, max cycles waiting on `mem_ready` before timeout (must be ≥1).
- `SUBI_OP`, 6'h09, opcode for `subi`.
- `JR_FUNCT`, 6'h08, funct identifying `jr` under opcode 0.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag, sampled in EXEC
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pc_write`  out  1  update PC
- `ir_write`  out  1  latch fetched word into IR
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `i_or_d`  out  1  0=PC address, 1=ALU address
- `reg_write`  out  1  register file write enable
- `reg_dst`  out  2  0=rt, 1=rd, 2=$31
- `mem_to_reg`  out  2  0=ALU, 1=MDR, 2=PC+4
- `alu_src`  out  1  0=reg, 1=sign-ext imm
- `alu_op`  out  `ALUOP_W`  0=add, 1=sub(beq), 2=addi, 3=subi, 4=R-type funct
- `pc_src`  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs
- `illegal`  out  1  sticky: unknown opcode seen
- `timeout`  out  1  sticky: `mem_ready` watchdog expired
- `busy`  out  1  high in every state except FETCH's first cycle

Behaviour:
- Clocking and reset:
  - Clock is `clk`; reset `rst_n` is asynchronous, active-low.
  - On reset the state is FETCH and the wait counter is 0.
  - Every output is 0 during reset, including `illegal` and `timeout`.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs:
  - Moore outputs, decoded from registered state plus `opcode`/`funct`.
  - No output depends combinationally on `mem_ready`, except that `pc_write`/`ir_write` in FETCH are gated by `mem_ready`.
- FETCH:
  - Asserts `mem_read` with `i_or_d`=0.
  - When `mem_ready`=1: assert `ir_write`=1 and `pc_write`=1 with `pc_src`=0, then go to DECODE.
  - When `mem_ready`=0: stay in FETCH and increment the wait counter.
- DECODE:
  - Decoded opcodes: 0x00, 0x23, 0x2B, 0x04, 0x02, 0x03, 0x08, `SUBI_OP`.
  - Any other opcode: set `illegal`, go to HALT.
  - j (0x02): `pc_write`=1, `pc_src`=2, then FETCH.
  - jal (0x03): `pc_write`=1, `pc_src`=2, `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2, then FETCH.
    - Writes the pre-jump PC+4; the datapath holds it in a PC+4 register.
  - jr (opcode 0, funct=`JR_FUNCT`): `pc_write`=1, `pc_src`=3, then FETCH.
  - All other decoded opcodes go to EXEC.
- EXEC:
  - lw/sw: `alu_src`=1, `alu_op`=0, then MEM.
  - beq: `alu_op`=1, `alu_src`=0. If `zero`=1, `pc_write`=1 with `pc_src`=1. Then FETCH.
  - R-type: `alu_op`=4, `alu_src`=0, then WB.
  - addi/subi: `alu_src`=1, `alu_op`=2 or 3 respectively, then WB.
- MEM:
  - `i_or_d`=1; lw asserts `mem_read`, sw asserts `mem_write`.
  - Holds until `mem_ready`, incrementing the wait counter meanwhile.
  - On `mem_ready`: sw goes to FETCH, lw goes to WB.
- WB:
  - `reg_write`=1.
  - lw: `reg_dst`=0, `mem_to_reg`=1.
  - R-type: `reg_dst`=1, `mem_to_reg`=0.
  - addi/subi: `reg_dst`=0, `mem_to_reg`=0.
  - Then FETCH.
- Wait counter:
  - Clears on every state change.
  - If it reaches `TIMEOUT_CYC` while waiting: set `timeout`, go to HALT; no strobes fire that cycle.
- HALT: all strobes 0, stays there until reset.
- Latency, assuming zero-wait memory:
  - j/jal/jr: 2 cycles.
  - beq: 3 cycles.
  - sw, R-type, addi, subi: 4 cycles.
  - lw: 5 cycles.
- Reset mid-instruction: immediately returns to FETCH with all strobes low; no partial `reg_write`/`mem_write` may occur after `rst_n` falls.
- Simultaneous `mem_ready` and counter reaching `TIMEOUT_CYC`: `mem_ready` wins and the transfer completes.

Decomposition:
- Shared package `cpu_pkg`:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI);
  - `alu_op`, `reg_dst`, `mem_to_reg` and `pc_src` encodings.
- Sub-module `mem_wait_timer`: counter plus expiry compare, parametrised by `TIMEOUT_CYC`.

Test Plan:
- **Reset/fetch:** release reset, `mem_ready`=1 → first cycle shows FETCH with `mem_read`=1, `ir_write`=1, `pc_write`=1; all other outputs 0.
- **lw with waits:** opcode 0x23, MEM wait of 3 cycles → sequence FETCH, DECODE, EXEC (`alu_src`=1, `alu_op`=0), MEM×4, WB (`reg_write`=1, `mem_to_reg`=1, `reg_dst`=0); total 8 cycles.
- **beq:**
  - opcode 0x04 with `zero`=1 → EXEC `pc_write`=1, `pc_src`=1.
  - with `zero`=0 → `pc_write`=0; next state FETCH in both cases.
- **Links:**
  - jal 0x03 → DECODE shows `reg_dst`=2, `mem_to_reg`=2, `reg_write`=1, `pc_src`=2.
  - opcode 0 with funct 0x08 → `pc_src`=3, `reg_write`=0.
- **addi/subi:** opcodes 0x08 and 0x09 → EXEC `alu_op`=2 and 3 respectively; WB `reg_dst`=0.
- **Errors:**
  - opcode 0x3F → `illegal`=1, HALT, strobes 0.
  - `mem_ready` held 0 for 15 cycles in FETCH → `timeout`=1.
  - `rst_n` pulsed low mid-MEM → returns to FETCH, no `mem_write` afterwards.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control path.
// Holds the FSM state enum, opcode constants, datapath mux encodings and the opcode decoder.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_ADDI  = 3'd2;
   localparam logic [2:0] ALU_SUBI  = 3'd3;
   localparam logic [2:0] ALU_FUNCT = 3'd4;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MDR = 2'd1;
   localparam logic [1:0] M2R_PC4 = 2'd2;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_RS     = 2'd3;

   typedef struct packed {
      logic rtype;
      logic jr;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic jal;
      logic addi;
      logic subi;
      logic legal;
   } decode_t;

   // subi and jr codes are parameters of the control block, so they are passed in.
   function automatic decode_t decode_op(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [5:0] subi_op, input logic [5:0] jr_funct);
      decode_t d;
      d       = '0;
      d.rtype = (op == OP_RTYPE) && (fn != jr_funct);
      d.jr    = (op == OP_RTYPE) && (fn == jr_funct);
      d.lw    = (op == OP_LW);
      d.sw    = (op == OP_SW);
      d.beq   = (op == OP_BEQ);
      d.j     = (op == OP_J);
      d.jal   = (op == OP_JAL);
      d.addi  = (op == OP_ADDI);
      d.subi  = (op == subi_op);
      d.legal = d.rtype | d.jr | d.lw | d.sw | d.beq | d.j | d.jal | d.addi | d.subi;
      return d;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready within one FSM state.
// expired is a pure compare on the registered count, so it never depends on mem_ready.
module mem_wait_timer #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic idle,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == CNT_W'(TIMEOUT_CYC));
   assign idle    = (count == '0);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake, jal/jr linkage, illegal-opcode trap and a mem_ready watchdog that halts the core.
module multicycle_control
   import cpu_pkg::*;
#(
   parameter int         ALUOP_W     = 3,
   parameter int         TIMEOUT_CYC = 15,
   parameter logic [5:0] SUBI_OP     = 6'h09,
   parameter logic [5:0] JR_FUNCT    = 6'h08
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               i_or_d,
   output logic               reg_write,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic               alu_src,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         pc_src,
   output logic               illegal,
   output logic               timeout,
   output logic               busy
);

   state_t  state;
   state_t  state_next;
   decode_t dec;
   logic    wait_idle;
   logic    wait_expired;
   logic    wait_cnt_en;
   logic    illegal_set;
   logic    timeout_set;
   logic    illegal_q;
   logic    timeout_q;

   assign dec         = decode_op(opcode, funct, SUBI_OP, JR_FUNCT);
   assign wait_cnt_en = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;

   mem_wait_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_mem_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_next != state),
      .count_en(wait_cnt_en),
      .idle    (wait_idle),
      .expired (wait_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_next;
         illegal_q <= illegal_q | illegal_set;
         timeout_q <= timeout_q | timeout_set;
      end
   end

   // mem_ready is checked before the watchdog so a completing transfer always wins.
   always_comb begin
      state_next  = state;
      illegal_set = 1'b0;
      timeout_set = 1'b0;
      case (state)
         S_FETCH: begin
            if (mem_ready) begin
               state_next = S_DECODE;
            end else if (wait_expired) begin
               state_next  = S_HALT;
               timeout_set = 1'b1;
            end
         end
         S_DECODE: begin
            if (!dec.legal) begin
               state_next  = S_HALT;
               illegal_set = 1'b1;
            end else if (dec.j || dec.jal || dec.jr) begin
               state_next = S_FETCH;
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (dec.lw || dec.sw) begin
               state_next = S_MEM;
            end else if (dec.rtype || dec.addi || dec.subi) begin
               state_next = S_WB;
            end else begin
               state_next = S_FETCH;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               state_next = dec.sw ? S_FETCH : S_WB;
            end else if (wait_expired) begin
               state_next  = S_HALT;
               timeout_set = 1'b1;
            end
         end
         S_WB:    state_next = S_FETCH;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_HALT;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = DST_RT;
      mem_to_reg = M2R_ALU;
      alu_src    = 1'b0;
      alu_op     = ALUOP_W'(ALU_ADD);
      pc_src     = PC_SEQ;
      busy       = 1'b1;
      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
            busy     = !wait_idle;
         end
         S_DECODE: begin
            if (dec.j) begin
               pc_write = 1'b1;
               pc_src   = PC_JUMP;
            end else if (dec.jal) begin
               pc_write   = 1'b1;
               pc_src     = PC_JUMP;
               reg_write  = 1'b1;
               reg_dst    = DST_RA;
               mem_to_reg = M2R_PC4;
            end else if (dec.jr) begin
               pc_write = 1'b1;
               pc_src   = PC_RS;
            end
         end
         S_EXEC: begin
            if (dec.lw || dec.sw) begin
               alu_src = 1'b1;
               alu_op  = ALUOP_W'(ALU_ADD);
            end else if (dec.beq) begin
               alu_op   = ALUOP_W'(ALU_SUB);
               pc_src   = PC_BRANCH;
               pc_write = zero;
            end else if (dec.rtype) begin
               alu_op = ALUOP_W'(ALU_FUNCT);
            end else if (dec.addi) begin
               alu_src = 1'b1;
               alu_op  = ALUOP_W'(ALU_ADDI);
            end else if (dec.subi) begin
               alu_src = 1'b1;
               alu_op  = ALUOP_W'(ALU_SUBI);
            end
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = dec.lw;
            mem_write = dec.sw;
         end
         S_WB: begin
            reg_write = 1'b1;
            if (dec.lw) begin
               reg_dst    = DST_RT;
               mem_to_reg = M2R_MDR;
            end else if (dec.rtype) begin
               reg_dst    = DST_RD;
               mem_to_reg = M2R_ALU;
            end
         end
         default: ;
      endcase
      // Asynchronous reset silences every strobe at once, even mid-instruction.
      if (!rst_n) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         i_or_d     = 1'b0;
         reg_write  = 1'b0;
         reg_dst    = DST_RT;
         mem_to_reg = M2R_ALU;
         alu_src    = 1'b0;
         alu_op     = '0;
         pc_src     = PC_SEQ;
         busy       = 1'b0;
      end
   end

   assign illegal = illegal_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors are queued
// when inputs are driven and compared against the packed DUT outputs mid-cycle.
module tb_multicycle_control;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
   logic [1:0] reg_dst, mem_to_reg, pc_src;
   logic       alu_src;
   logic [2:0] alu_op;
   logic       illegal, timeout, busy;

   logic [18:0] exp_q[$];
   logic [18:0] got;
   int          n_tests = 0;
   int          n_fail  = 0;

   multicycle_control #(
      .ALUOP_W    (3),
      .TIMEOUT_CYC(15),
      .SUBI_OP    (6'h09),
      .JR_FUNCT   (6'h08)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .funct     (funct),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pc_write  (pc_write),
      .ir_write  (ir_write),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .i_or_d    (i_or_d),
      .reg_write (reg_write),
      .reg_dst   (reg_dst),
      .mem_to_reg(mem_to_reg),
      .alu_src   (alu_src),
      .alu_op    (alu_op),
      .pc_src    (pc_src),
      .illegal   (illegal),
      .timeout   (timeout),
      .busy      (busy)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign got = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
                 mem_to_reg, alu_src, alu_op, pc_src, illegal, timeout, busy};

   function automatic logic [18:0] mk(input logic pcw, input logic irw, input logic mrd,
                                      input logic mwr, input logic iod, input logic rw,
                                      input logic [1:0] rdst, input logic [1:0] m2r,
                                      input logic asrc, input logic [2:0] aop,
                                      input logic [1:0] psrc, input logic ill,
                                      input logic to, input logic bsy);
      return {pcw, irw, mrd, mwr, iod, rw, rdst, m2r, asrc, aop, psrc, ill, to, bsy};
   endfunction

   function automatic logic [18:0] e_fetch(input logic rdy, input logic bsy);
      return mk(rdy, rdy, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, bsy);
   endfunction

   function automatic logic [18:0] e_quiet(input logic ill, input logic to);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, ill, to, 1'b1);
   endfunction

   // Scoreboard compare
   task automatic check(input string tag);
      logic [18:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %h with no expected entry queued", tag, got);
      end else begin
         e = exp_q.pop_front();
         assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
         end
      end
   endtask

   // Driver: one clock cycle with a queued expectation for that cycle's outputs
   task automatic cyc(input logic [18:0] e, input logic mr, input string tag);
      exp_q.push_back(e);
      mem_ready = mr;
      #4;
      check(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #2;
      exp_q.push_back('0);
      check(tag);
      @(posedge clk);
      #1;
      exp_q.push_back('0);
      check({tag, "_held"});
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      do_reset("reset");

      // R-type add
      opcode = 6'h00; funct = 6'h20;
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "r_fetch");
      cyc(e_quiet(1'b0, 1'b0), 1'b1, "r_decode");
      cyc(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd4, 2'd0, 0, 0, 1), 1'b1, "r_exec");
      cyc(mk(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 3'd0, 2'd0, 0, 0, 1), 1'b1, "r_wb");

      // lw with three memory wait cycles
      opcode = 6'h23; funct = 6'h00;
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "lw_fetch");
      cyc(e_quiet(1'b0, 1'b0), 1'b1, "lw_decode");
      cyc(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 3'd0, 2'd0, 0, 0, 1), 1'b1, "lw_exec");
      for (int k = 0; k < 4; k++)
         cyc(mk(0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 3'd0, 2'd0, 0, 0, 1), (k == 3),
             $sformatf("lw_mem%0d", k));
      cyc(mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 3'd0, 2'd0, 0, 0, 1), 1'b1, "lw_wb");

      // sw
      opcode = 6'h2B;
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "sw_fetch");
      cyc(e_quiet(1'b0, 1'b0), 1'b1, "sw_decode");
      cyc(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 3'd0, 2'd0, 0, 0, 1), 1'b1, "sw_exec");
      cyc(mk(0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 3'd0, 2'd0, 0, 0, 1), 1'b1, "sw_mem");

      // beq taken then not taken
      opcode = 6'h04; zero = 1'b1;
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "beq1_fetch");
      cyc(e_quiet(1'b0, 1'b0), 1'b1, "beq1_decode");
      cyc(mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd1, 2'd1, 0, 0, 1), 1'b1, "beq1_exec");
      zero = 1'b0;
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "beq0_fetch");
      cyc(e_quiet(1'b0, 1'b0), 1'b1, "beq0_decode");
      cyc(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd1, 2'd1, 0, 0, 1), 1'b1, "beq0_exec");

      // jal
      opcode = 6'h03;
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "jal_fetch");
      cyc(mk(1, 0, 0, 0, 0, 1, 2'd2, 2'd2, 0, 3'd0, 2'd2, 0, 0, 1), 1'b1, "jal_decode");

      // j with two fetch wait cycles
      opcode = 6'h02;
      cyc(e_fetch(1'b0, 1'b0), 1'b0, "j_fetchw0");
      cyc(e_fetch(1'b0, 1'b1), 1'b0, "j_fetchw1");
      cyc(e_fetch(1'b1, 1'b1), 1'b1, "j_fetch");
      cyc(mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 2'd2, 0, 0, 1), 1'b1, "j_decode");

      // jr
      opcode = 6'h00; funct = 6'h08;
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "jr_fetch");
      cyc(mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 2'd3, 0, 0, 1), 1'b1, "jr_decode");

      // addi and subi
      opcode = 6'h08; funct = 6'h00;
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "addi_fetch");
      cyc(e_quiet(1'b0, 1'b0), 1'b1, "addi_decode");
      cyc(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 3'd2, 2'd0, 0, 0, 1), 1'b1, "addi_exec");
      cyc(mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 3'd0, 2'd0, 0, 0, 1), 1'b1, "addi_wb");
      opcode = 6'h09;
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "subi_fetch");
      cyc(e_quiet(1'b0, 1'b0), 1'b1, "subi_decode");
      cyc(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 3'd3, 2'd0, 0, 0, 1), 1'b1, "subi_exec");
      cyc(mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 3'd0, 2'd0, 0, 0, 1), 1'b1, "subi_wb");

      // sw interrupted by reset in MEM, then an illegal opcode
      opcode = 6'h2B;
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "swr_fetch");
      cyc(e_quiet(1'b0, 1'b0), 1'b1, "swr_decode");
      cyc(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 3'd0, 2'd0, 0, 0, 1), 1'b1, "swr_exec");
      mem_ready = 1'b0;
      #2;
      exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 3'd0, 2'd0, 0, 0, 1));
      check("swr_mem");
      do_reset("swr_reset");
      opcode = 6'h3F;
      cyc(e_fetch(1'b0, 1'b0), 1'b0, "swr_refetch_wait");
      cyc(e_fetch(1'b1, 1'b1), 1'b1, "ill_fetch");
      cyc(e_quiet(1'b0, 1'b0), 1'b1, "ill_decode");
      cyc(e_quiet(1'b1, 1'b0), 1'b1, "ill_halt0");
      cyc(e_quiet(1'b1, 1'b0), 1'b1, "ill_halt1");

      // Fetch watchdog: mem_ready never arrives
      do_reset("tmo_reset");
      for (int k = 0; k < 16; k++)
         cyc(e_fetch(1'b0, (k != 0)), 1'b0, $sformatf("tmo_fetch%0d", k));
      cyc(e_quiet(1'b0, 1'b1), 1'b1, "tmo_halt0");
      cyc(e_quiet(1'b0, 1'b1), 1'b1, "tmo_halt1");

      // mem_ready on the expiry cycle wins over the watchdog
      do_reset("race_reset");
      opcode = 6'h02;
      for (int k = 0; k < 15; k++)
         cyc(e_fetch(1'b0, (k != 0)), 1'b0, $sformatf("race_fetch%0d", k));
      cyc(e_fetch(1'b1, 1'b1), 1'b1, "race_fetch15");
      cyc(mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 2'd2, 0, 0, 1), 1'b1, "race_decode");
      cyc(e_fetch(1'b1, 1'b0), 1'b1, "race_refetch");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
